// File: rtl/ledsuit_pkg.sv
// Shared LED-suit definitions: WS2812 timing defaults, ns-to-cycle conversion
// and the serializer state encoding used by the strip driver and its bench.
package ledsuit_pkg;

  localparam int WS_CLK_FREQ_MHZ = 50;
  localparam int WS_T0H_NS       = 350;
  localparam int WS_T1H_NS       = 700;
  localparam int WS_BIT_NS       = 1250;
  localparam int WS_RESET_US     = 80;

  // Truncates, so a pulse never exceeds its nominal width.
  function automatic int ns_to_cycles(input int ns, input int mhz);
    return (ns * mhz) / 1000;
  endfunction

  typedef enum logic [2:0] {
    SER_IDLE,
    SER_HIGH,
    SER_LOW,
    SER_WAIT,
    SER_LATCH
  } ser_state_e;

endpackage

// File: rtl/ws2812_serializer.sv
// WS2812 one-wire line encoder: turns a valid/ready stream of GRB bytes into
// NRZ bit pulses followed by the end-of-frame latch gap.
module ws2812_serializer
  import ledsuit_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = WS_CLK_FREQ_MHZ,
  parameter int T0H_NS       = WS_T0H_NS,
  parameter int T1H_NS       = WS_T1H_NS,
  parameter int BIT_NS       = WS_BIT_NS,
  parameter int RESET_US     = WS_RESET_US
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       strip_out,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int T0H_CYC   = ns_to_cycles(T0H_NS, CLK_FREQ_MHZ);
  localparam int T1H_CYC   = ns_to_cycles(T1H_NS, CLK_FREQ_MHZ);
  localparam int BIT_CYC   = ns_to_cycles(BIT_NS, CLK_FREQ_MHZ);
  localparam int RESET_CYC = ns_to_cycles(RESET_US * 1000, CLK_FREQ_MHZ);
  localparam int MAX_CYC   = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter holds "cycles remaining minus one" in the current phase.
  localparam cnt_t T0H_LD = cnt_t'(T0H_CYC - 1);
  localparam cnt_t T1H_LD = cnt_t'(T1H_CYC - 1);
  localparam cnt_t T0L_LD = cnt_t'(BIT_CYC - T0H_CYC - 1);
  localparam cnt_t T1L_LD = cnt_t'(BIT_CYC - T1H_CYC - 1);
  localparam cnt_t RST_LD = cnt_t'(RESET_CYC - 1);

  if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC >= 1))
    begin : g_bad_timing
      $error("ws2812_serializer: need 1 <= T0H_CYC < T1H_CYC < BIT_CYC and RESET_CYC >= 1");
    end

  ser_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       last_q, last_d;
  logic       strip_q, strip_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       under_q, under_d;
  logic       accept;

  assign accept = in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    under_d = 1'b0;

    unique case (state_q)
      SER_IDLE: begin
        if (accept) begin
          shift_d = in_data;
          last_d  = in_last;
          idx_d   = 3'd7;
          state_d = SER_HIGH;
          cnt_d   = in_data[7] ? T1H_LD : T0H_LD;
        end
      end
      SER_HIGH: begin
        if (cnt_q == '0) begin
          state_d = SER_LOW;
          cnt_d   = shift_q[7] ? T1L_LD : T0L_LD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      SER_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_t'(1);
        end else if (idx_q != 3'd0) begin
          shift_d = {shift_q[6:0], 1'b0};
          idx_d   = idx_q - 3'd1;
          state_d = SER_HIGH;
          cnt_d   = shift_q[6] ? T1H_LD : T0H_LD;
        end else if (last_q) begin
          state_d = SER_LATCH;
          cnt_d   = RST_LD;
        end else if (accept) begin
          shift_d = in_data;
          last_d  = in_last;
          idx_d   = 3'd7;
          state_d = SER_HIGH;
          cnt_d   = in_data[7] ? T1H_LD : T0H_LD;
        end else begin
          state_d = SER_WAIT;
          cnt_d   = RST_LD;
        end
      end
      SER_WAIT: begin
        if (accept) begin
          shift_d = in_data;
          last_d  = in_last;
          idx_d   = 3'd7;
          state_d = SER_HIGH;
          cnt_d   = in_data[7] ? T1H_LD : T0H_LD;
        end else if (cnt_q == '0) begin
          state_d = SER_IDLE;
          under_d = 1'b1;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      SER_LATCH: begin
        if (cnt_q == '0) begin
          state_d = SER_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: state_d = SER_IDLE;
    endcase

    // Outputs decode the next state so they can be registered without lag.
    strip_d = (state_d == SER_HIGH);
    busy_d  = (state_d != SER_IDLE);
    ready_d = (state_d == SER_IDLE) || (state_d == SER_WAIT) ||
              ((state_d == SER_LOW) && (cnt_d == '0) && (idx_d == 3'd0) && !last_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      strip_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      strip_q <= strip_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

  assign in_ready   = ready_q;
  assign strip_out  = strip_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = under_q;

endmodule

// File: doc/ws2812_serializer.md
Name: ws2812_serializer

Overview:
- Bit-level line encoder for one LED strip output pin.
- Consumes a stream of 8-bit channel bytes (GRB order, already fetched from BRAM by the strip driver / arbiter path) over a valid/ready handshake.
- Emits the WS2812 one-wire NRZ waveform plus the end-of-frame latch gap.
- Frame-level byte sequencing stays upstream; this block owns pulse timing.

Parameters:
- CLK_FREQ_MHZ, 50, core clock frequency in MHz.
- T0H_NS, 350, high time for a 0 bit.
- T1H_NS, 700, high time for a 1 bit.
- BIT_NS, 1250, total bit period.
- RESET_US, 80, latch low time after the last byte.
- Derived cycle counts (floor of ns*MHz/1000) at defaults: T0H_CYC=17, T1H_CYC=35, BIT_CYC=62, RESET_CYC=4000.
- Elaboration error unless 1 <= T0H_CYC < T1H_CYC < BIT_CYC.

Ports:
- clk  in  1  core clock (clk_50mhz domain).
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  channel byte, sent MSB first.
- in_last  in  1  qualifies in_data as the final byte of a frame.
- in_ready  out  1  byte accepted on a cycle with in_valid && in_ready.
- strip_out  out  1  registered line output.
- busy  out  1  high from byte acceptance until return to IDLE.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.
- underrun  out  1  one-cycle pulse when the stream starves mid-frame past the latch limit.

Behaviour:
- Reset state (async assert, sync release): strip_out=0, in_ready=0, busy=0, frame_done=0, underrun=0, state=IDLE.
- Reset mid-bit drops strip_out to 0 immediately. No partial byte resumes after reset.
- States: IDLE, HIGH, LOW, WAIT, LATCH.
- IDLE:
  - in_ready=1.
  - On accept at cycle N: load shift register, store last flag, set bit index 7.
  - strip_out=1 from cycle N+1; go to HIGH.
- HIGH:
  - strip_out=1 for exactly T1H_CYC or T0H_CYC cycles, chosen by the current MSB; then go to LOW.
- LOW:
  - strip_out=0 for BIT_CYC minus the HIGH length, so every bit is exactly BIT_CYC cycles (62).
  - Ordinary bit end: shift left, decrement index, go to HIGH.
  - Final cycle of bit 0:
    - If last flag is set: go to LATCH, with in_ready=0.
    - Else in_ready=1 for that single cycle. On accept, the next byte's first HIGH starts the following cycle, so back-to-back bytes are gapless (one byte = 496 cycles).
    - Else (no byte offered): go to WAIT.
- WAIT:
  - strip_out=0, in_ready=1, counter runs.
  - Accept before the counter reaches RESET_CYC: resume HIGH on the next cycle. Pixels stay coherent because the gap is below the latch threshold.
  - Counter reaches RESET_CYC: pulse underrun, go to IDLE with no frame_done.
- LATCH:
  - strip_out=0, in_ready=0 for RESET_CYC cycles.
  - Final cycle: pulse frame_done, go to IDLE.
- busy=1 in HIGH, LOW, WAIT and LATCH.
- Simultaneous events:
  - in_valid without in_ready is ignored; in_data is not sampled.
  - in_last on a byte accepted in IDLE gives a single-byte frame, which is legal.
- Counter width is $clog2(max(BIT_CYC,RESET_CYC)+1), 12 bits at defaults. It loads and compares without wrap-around.
- All outputs are registered. No combinational path from inputs to outputs except none; in_ready is a state decode.

Decomposition:
- Shared package ledsuit_pkg holds:
  - the ns_to_cycles constant function;
  - the default WS2812 timing constants;
  - the serializer state enum, so strip_driver and the bench share it.
- No sub-module. A single FSM plus one down-counter and a shift register is natural at about 150–250 lines.

Test Plan:
- Accept 0xA5 with in_last=1 from IDLE:
  - strip_out high-times are 35,17,35,17,17,35,17,35 cycles, each bit 62 cycles.
  - Then 4000 low cycles, then frame_done pulses exactly once; busy falls the same cycle.
- Stream 0xFF, 0x00, 0x81 (last) with in_valid held high:
  - in_ready is seen once per byte on the final LOW cycle.
  - No idle cycle appears between bytes; total frame is 3*496+4000 cycles to frame_done.
- Starve 100 cycles after the first byte of a two-byte frame:
  - WAIT holds strip_out=0; the second byte resumes correctly; no underrun.
- Starve 4000 cycles after a non-last byte:
  - underrun pulses, frame_done stays 0, block returns to IDLE with in_ready=1.
- Assert rst_n low during the HIGH phase of bit 3:
  - strip_out=0 asynchronously and all outputs reach reset values.
  - After release, a new byte 0x01 encodes cleanly from bit 7.
- Hold in_valid=1 during LATCH:
  - in_ready stays 0 and no byte is consumed until IDLE; that byte is then accepted on the first IDLE cycle.
